// File: rtl/cla_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cla_accum_ctrl
//  Purpose  : Accumulates a batch of N_OPS unsigned 8-bit operands using an
//             external combinational 8-bit carry-lookahead adder for the low
//             byte. The adder's carry ripples into the upper accumulator
//             bits. When a batch is complete, the total is presented
//             downstream and then cleared.
//  Ports    : clk, rst_n (sync, active-low), clr (sync batch abort)
//             in_valid/in_ready/in_data  : operand stream
//             cla_a/cla_b -> cla_8bit, cla_sum <- cla_8bit (9 bits)
//             out_valid/out_ready/out_sum/out_ovf : batch result stream
//  Revision : 1.0 - initial release
// ============================================================================
module cla_accum_ctrl #(
    parameter int N_OPS = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       cla_a,
    output logic [7:0]       cla_b,
    input  logic [8:0]       cla_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(N_OPS + 1);
    localparam int HI_W  = ACC_W - 8;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic [HI_W:0]    hi_sum;

    // The adder sees the low byte of the running total and the raw operand.
    assign cla_a = acc_q[7:0];
    assign cla_b = in_data;

    assign beat = in_valid & in_ready;

    // Upper bits absorb the adder's carry; the extra MSB is the wrap-out.
    assign hi_sum = {1'b0, acc_q[ACC_W-1:8]} + {{HI_W{1'b0}}, cla_sum[8]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            // Abort wins over any handshake in the same cycle.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (beat) begin
                        acc_d = {hi_sum[HI_W-1:0], cla_sum[7:0]};
                        ovf_d = ovf_q | hi_sum[HI_W];
                        if (cnt_q == CNT_W'(N_OPS - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = rst_n && (state_q == ST_ACC);
        out_valid = (state_q == ST_HOLD);
        out_sum   = out_valid ? acc_q : '0;
        out_ovf   = out_valid & ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_accum_ctrl
//  Purpose  : Self-checking bench for cla_accum_ctrl. A default-parameter
//             instance is tracked cycle by cycle against a transaction-level
//             model (running batch total as an integer). A second instance
//             with N_OPS=300 covers accumulator wrap and the sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_accum_ctrl;

    localparam int N_DEF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst_n, clr, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_ovf;
    logic [7:0]  cla_a, cla_b;
    logic [8:0]  cla_sum;
    logic [15:0] out_sum;

    assign cla_sum = {1'b0, cla_a} + {1'b0, cla_b};

    cla_accum_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cla_a(cla_a), .cla_b(cla_b), .cla_sum(cla_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    // Long-batch instance
    logic        b_rst_n, b_clr, b_in_valid, b_out_ready;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_cla_a, b_cla_b;
    logic [8:0]  b_cla_sum;
    logic [15:0] b_out_sum;

    assign b_cla_sum = {1'b0, b_cla_a} + {1'b0, b_cla_b};

    cla_accum_ctrl #(.N_OPS(300), .ACC_W(16)) u_big (
        .clk(clk), .rst_n(b_rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .cla_a(b_cla_a), .cla_b(b_cla_b), .cla_sum(b_cla_sum),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: result pending flag, unbounded batch total, beat count.
    bit     m_pend  = 1'b0;
    longint m_total = 0;
    int     m_cnt   = 0;

    typedef struct {
        logic [3:0][7:0] d;
        int              gap;
        logic [15:0]     exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(rst_n && !m_pend));
        chk("out_valid", 32'(out_valid), 32'(m_pend));
        chk("cla_a", 32'(cla_a), 32'(m_total[7:0]));
        chk("cla_b", 32'(cla_b), 32'(in_data));
        if (m_pend) begin
            chk("out_sum", 32'(out_sum), 32'(m_total[15:0]));
            chk("out_ovf", 32'(out_ovf), 32'(m_total > 65535));
        end
    endtask

    // Advance the model with the inputs currently applied, clock once, compare.
    task automatic tick();
        if (!rst_n || clr) begin
            m_pend = 1'b0; m_total = 0; m_cnt = 0;
        end else if (m_pend) begin
            if (out_ready) begin
                m_pend = 1'b0; m_total = 0;
            end
        end else if (in_valid) begin
            m_total += longint'(in_data);
            m_cnt++;
            if (m_cnt == N_DEF) begin
                m_cnt  = 0;
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0; in_data = 8'($urandom);
                tick();
            end
            beat(v.d[i]);
        end
        chk($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_sum", idx), 32'(out_sum), 32'(v.exp_sum));
        chk($sformatf("vec%0d_ovf", idx), 32'(out_ovf), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] held;

        vecs[0] = '{d: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, gap: 0, exp_sum: 16'h03FC};
        vecs[1] = '{d: {8'h04, 8'h03, 8'h02, 8'h01}, gap: 2, exp_sum: 16'h000A};
        vecs[2] = '{d: {8'h00, 8'h00, 8'h00, 8'h00}, gap: 1, exp_sum: 16'h0000};
        vecs[3] = '{d: {8'h80, 8'h80, 8'h80, 8'h80}, gap: 0, exp_sum: 16'h0200};
        vecs[4] = '{d: {8'h78, 8'h56, 8'h34, 8'h12}, gap: 3, exp_sum: 16'h0114};
        vecs[5] = '{d: {8'hFF, 8'h00, 8'hFF, 8'h01}, gap: 0, exp_sum: 16'h01FF};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        b_rst_n = 1'b0; b_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Table-driven batches
        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Long batch: 300 x FF wraps 16 bits and sets ovf
        b_out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            b_in_valid = 1'b1; b_in_data = 8'hFF;
            tick();
        end
        b_in_valid = 1'b0;
        chk("big_valid", 32'(b_out_valid), 32'd1);
        chk("big_sum", 32'(b_out_sum), 32'h2AD4);
        chk("big_ovf", 32'(b_out_ovf), 32'd1);
        chk("big_in_ready", 32'(b_in_ready), 32'd0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            b_in_valid = 1'b1; b_in_data = 8'h01;
            tick();
        end
        b_in_valid = 1'b0;
        chk("big2_valid", 32'(b_out_valid), 32'd1);
        chk("big2_sum", 32'(b_out_sum), 32'h012C);
        chk("big2_ovf", 32'(b_out_ovf), 32'd0);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;

        // Backpressure: result held while out_ready=0 and beats are offered
        for (int i = 0; i < 4; i++) beat(8'h11 * 8'(i + 1));
        held = out_sum;
        chk("bp_sum0", 32'(held), 32'h00AA);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h55;
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_held", 32'(out_sum), 32'(held));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);

        // clr drops the partial batch and the beat offered with it
        beat(8'h10);
        beat(8'h20);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'h01);
        chk("clr_sum", 32'(out_sum), 32'h0004);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-batch, then in HOLD
        beat(8'h07);
        beat(8'h07);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'h09);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'h05);
        chk("rst_after_sum", 32'(out_sum), 32'h0014);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            clr       = ($urandom_range(0, 49) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
